// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer for a multicycle RV32 subset datapath.
module multicycle_control_unit #(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic                instr_valid,
  input  logic                mem_ready,
  input  logic                trap_ack,
  output logic                fetch_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                alu_src,
  output logic                branch,
  output logic                jump,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                trap,
  output logic                trap_cause,
  output logic [2:0]          state_dbg
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} state_t;
  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);
  state_t state, state_nx;
  logic [6:0] opcode_q;
  logic [7:0] cnt;
  logic cause_q, cause_nx;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, legal;
  assign is_r   = opcode_q == 7'b0110011;
  assign is_i   = opcode_q == 7'b0010011;
  assign is_ld  = opcode_q == 7'b0000011;
  assign is_st  = opcode_q == 7'b0100011;
  assign is_br  = opcode_q == 7'b1100011;
  assign is_jal = opcode_q == 7'b1101111;
  assign legal  = is_r | is_i | is_ld | is_st | is_br | is_jal;
  assign state_dbg = state;
  // The wait counter is held at zero outside MEM, so it is already clear on MEM entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      opcode_q <= '0;
      cnt      <= '0;
      cause_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cause_q <= cause_nx;
      if (ir_write) opcode_q <= opcode;
      cnt <= (state != MEM) ? 8'd0 : (mem_ready ? cnt : cnt + 8'd1);
    end
  end
  always_comb begin
    state_nx   = state;
    cause_nx   = cause_q;
    fetch_req  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = '0;
    trap       = 1'b0;
    trap_cause = 1'b0;
    case (state)
      FETCH: begin
        fetch_req = rst_n;
        ir_write  = rst_n & instr_valid;
        state_nx  = instr_valid ? DECODE : FETCH;
      end
      DECODE: begin
        state_nx = legal ? EXEC : TRAP;
        cause_nx = legal ? cause_q : 1'b0;
      end
      EXEC: begin
        alu_src  = is_i | is_ld | is_st;
        alu_op   = (is_r | is_i) ? ALU_OP_W'(2) : (is_br ? ALU_OP_W'(1) : ALU_OP_W'(0));
        branch   = is_br;
        jump     = is_jal;
        pc_write = is_br | is_jal;
        state_nx = is_br ? FETCH : ((is_ld | is_st) ? MEM : WB);
      end
      MEM: begin
        mem_read  = is_ld;
        mem_write = is_st;
        pc_write  = mem_ready & is_st;
        state_nx  = mem_ready ? (is_st ? FETCH : WB) : (cnt >= LAST ? TRAP : MEM);
        cause_nx  = (!mem_ready && cnt >= LAST) ? 1'b1 : cause_q;
      end
      WB: begin
        reg_write = 1'b1;
        pc_write  = ~is_jal;
        state_nx  = FETCH;
      end
      TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
        state_nx   = trap_ack ? FETCH : TRAP;
      end
      default: state_nx = FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed per-cycle stimulus with a queue scoreboard of expected output vectors.
module tb_multicycle_control_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic instr_valid = 1'b0, mem_ready = 1'b0, trap_ack = 1'b0;
  logic fetch_req, ir_write, pc_write, reg_write, alu_src, branch, jump, mem_read, mem_write;
  logic [2:0] alu_op, state_dbg;
  logic trap, trap_cause;
  int n_vec = 0, n_bad = 0;
  logic [16:0] sb[$];
  localparam logic [2:0] F = 3'd0, D = 3'd1, X = 3'd2, M = 3'd3, W = 3'd4, T = 3'd5;
  localparam logic [8:0] FR = 9'h100, IW = 9'h080, PW = 9'h040, RW = 9'h020, AS = 9'h010,
                         BR = 9'h008, JP = 9'h004, MR = 9'h002, MW = 9'h001, NO = 9'h000;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_BAD = 7'b1111111;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_valid(instr_valid), .mem_ready(mem_ready),
    .trap_ack(trap_ack), .fetch_req(fetch_req), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src(alu_src), .branch(branch), .jump(jump), .mem_read(mem_read),
    .mem_write(mem_write), .alu_op(alu_op), .trap(trap), .trap_cause(trap_cause), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] e(input logic [2:0] st, input logic [8:0] c, input logic [2:0] a,
                                    input logic tr, input logic tc);
    return {c, a, tr, tc, st};
  endfunction

  task automatic cyc(input string tag, input logic rn, input logic [6:0] op, input logic iv,
                     input logic mr, input logic ta, input logic [16:0] x);
    logic [16:0] got, want;
    @(posedge clk);
    #1;
    rst_n = rn; opcode = op; instr_valid = iv; mem_ready = mr; trap_ack = ta;
    sb.push_back(x);
    @(negedge clk);
    want = sb.pop_front();
    got = {fetch_req, ir_write, pc_write, reg_write, alu_src, branch, jump, mem_read, mem_write,
           alu_op, trap, trap_cause, state_dbg};
    n_vec++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  initial begin
    cyc("reset0", 0, 7'h00, 0, 0, 0, e(F, NO, 0, 0, 0));
    cyc("reset1", 0, OP_R, 1, 1, 1, e(F, NO, 0, 0, 0));
    // R-type; opcode bus changed after fetch to prove decode uses the latched copy
    cyc("r_fetch", 1, OP_R, 1, 0, 0, e(F, FR | IW, 0, 0, 0));
    cyc("r_dec", 1, OP_BAD, 0, 0, 0, e(D, NO, 0, 0, 0));
    cyc("r_exec", 1, OP_BAD, 0, 0, 0, e(X, NO, 2, 0, 0));
    cyc("r_wb", 1, OP_BAD, 0, 0, 0, e(W, RW | PW, 0, 0, 0));
    cyc("idle_ack", 1, 7'h00, 0, 0, 1, e(F, FR, 0, 0, 0));
    // I-type
    cyc("i_fetch", 1, OP_I, 1, 0, 0, e(F, FR | IW, 0, 0, 0));
    cyc("i_dec", 1, OP_I, 0, 0, 0, e(D, NO, 0, 0, 0));
    cyc("i_exec", 1, OP_I, 0, 0, 0, e(X, AS, 2, 0, 0));
    cyc("i_wb", 1, OP_I, 0, 0, 0, e(W, RW | PW, 0, 0, 0));
    // LOAD with 3 wait cycles
    cyc("ld_fetch", 1, OP_LD, 1, 0, 0, e(F, FR | IW, 0, 0, 0));
    cyc("ld_dec", 1, OP_LD, 0, 0, 0, e(D, NO, 0, 0, 0));
    cyc("ld_exec", 1, OP_LD, 0, 0, 0, e(X, AS, 0, 0, 0));
    for (int i = 0; i < 3; i++) cyc("ld_wait", 1, OP_LD, 0, 0, 0, e(M, MR, 0, 0, 0));
    cyc("ld_done", 1, OP_LD, 0, 1, 0, e(M, MR, 0, 0, 0));
    cyc("ld_wb", 1, OP_LD, 0, 0, 0, e(W, RW | PW, 0, 0, 0));
    // STORE timeout
    cyc("st_fetch", 1, OP_ST, 1, 0, 0, e(F, FR | IW, 0, 0, 0));
    cyc("st_dec", 1, OP_ST, 0, 0, 0, e(D, NO, 0, 0, 0));
    cyc("st_exec", 1, OP_ST, 0, 0, 0, e(X, AS, 0, 0, 0));
    for (int i = 0; i < 16; i++) cyc("st_wait", 1, OP_ST, 0, 0, 0, e(M, MW, 0, 0, 0));
    cyc("st_trap", 1, OP_ST, 0, 1, 0, e(T, NO, 0, 1, 1));
    cyc("st_ack", 1, OP_ST, 0, 0, 1, e(T, NO, 0, 1, 1));
    cyc("st_back", 1, OP_ST, 0, 0, 0, e(F, FR, 0, 0, 0));
    // illegal opcode, trap held for 10 cycles
    cyc("bad_fetch", 1, OP_BAD, 1, 0, 0, e(F, FR | IW, 0, 0, 0));
    cyc("bad_dec", 1, OP_BAD, 0, 0, 0, e(D, NO, 0, 0, 0));
    for (int i = 0; i < 10; i++) cyc("bad_trap", 1, OP_BAD, 0, 0, 0, e(T, NO, 0, 1, 0));
    cyc("bad_ack", 1, OP_BAD, 0, 0, 1, e(T, NO, 0, 1, 0));
    // BRANCH then JAL back-to-back
    cyc("br_fetch", 1, OP_BR, 1, 0, 0, e(F, FR | IW, 0, 0, 0));
    cyc("br_dec", 1, OP_BR, 0, 0, 0, e(D, NO, 0, 0, 0));
    cyc("br_exec", 1, OP_BR, 0, 0, 0, e(X, BR | PW, 1, 0, 0));
    cyc("jal_fetch", 1, OP_JAL, 1, 0, 0, e(F, FR | IW, 0, 0, 0));
    cyc("jal_dec", 1, OP_JAL, 0, 0, 0, e(D, NO, 0, 0, 0));
    cyc("jal_exec", 1, OP_JAL, 0, 0, 0, e(X, JP | PW, 0, 0, 0));
    cyc("jal_wb", 1, OP_JAL, 0, 0, 0, e(W, RW, 0, 0, 0));
    // STORE completing normally
    cyc("st2_fetch", 1, OP_ST, 1, 0, 0, e(F, FR | IW, 0, 0, 0));
    cyc("st2_dec", 1, OP_ST, 0, 0, 0, e(D, NO, 0, 0, 0));
    cyc("st2_exec", 1, OP_ST, 0, 0, 0, e(X, AS, 0, 0, 0));
    cyc("st2_wait", 1, OP_ST, 0, 0, 0, e(M, MW, 0, 0, 0));
    cyc("st2_done", 1, OP_ST, 0, 1, 0, e(M, MW | PW, 0, 0, 0));
    cyc("st2_back", 1, OP_ST, 0, 0, 0, e(F, FR, 0, 0, 0));
    // LOAD where mem_ready arrives on the last allowed cycle
    cyc("ld2_fetch", 1, OP_LD, 1, 0, 0, e(F, FR | IW, 0, 0, 0));
    cyc("ld2_dec", 1, OP_LD, 0, 0, 0, e(D, NO, 0, 0, 0));
    cyc("ld2_exec", 1, OP_LD, 0, 0, 0, e(X, AS, 0, 0, 0));
    for (int i = 0; i < 15; i++) cyc("ld2_wait", 1, OP_LD, 0, 0, 0, e(M, MR, 0, 0, 0));
    cyc("ld2_last", 1, OP_LD, 0, 1, 0, e(M, MR, 0, 0, 0));
    cyc("ld2_wb", 1, OP_LD, 0, 0, 0, e(W, RW | PW, 0, 0, 0));
    // reset pulse in the middle of a LOAD MEM phase
    cyc("ld3_fetch", 1, OP_LD, 1, 0, 0, e(F, FR | IW, 0, 0, 0));
    cyc("ld3_dec", 1, OP_LD, 0, 0, 0, e(D, NO, 0, 0, 0));
    cyc("ld3_exec", 1, OP_LD, 0, 0, 0, e(X, AS, 0, 0, 0));
    cyc("ld3_mem", 1, OP_LD, 0, 0, 0, e(M, MR, 0, 0, 0));
    cyc("ld3_rst", 0, OP_LD, 0, 0, 0, e(F, NO, 0, 0, 0));
    cyc("ld3_post", 1, OP_LD, 0, 0, 0, e(F, FR, 0, 0, 0));
    cyc("ld3_idle", 1, OP_LD, 0, 1, 0, e(F, FR, 0, 0, 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
